// File: rtl/sample_framer_if.sv
// Bus bundle for sample_framer: ADC sample strobe in, ping-pong frame hand-off
// and random-access read port out.
interface sample_framer_if #(
  parameter int ADDR_W = 6
);
  // Handshakes: sample_valid is a one-cycle strobe with no back-pressure (each
  // strobe is always accepted). frame_ready=1 means the read bank holds a
  // complete frame. A one-cycle frame_ack releases it, and frame_ack has no
  // effect while frame_ready=0. rd_data answers rd_addr one cycle later.
  logic              sample_valid;
  logic [11:0]       sample_data;
  logic              frame_ready;
  logic              frame_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [11:0]       rd_data;
  logic              overrun;

  modport master (
    output sample_valid, sample_data, frame_ack, rd_addr,
    input  frame_ready, rd_data, overrun
  );

  modport slave (
    input  sample_valid, sample_data, frame_ack, rd_addr,
    output frame_ready, rd_data, overrun
  );
endinterface

// File: rtl/sample_framer.sv
// Ping-pong ADC sample framer: offset-binary to signed conversion, two frame banks.
// Optional 2-sample averaging is enabled by defining SAMPLE_AVG2_EN.
module sample_framer #(
  parameter int FRAME_LEN = 64,
  parameter int ADDR_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
  sample_framer_if.slave   bus,
  output logic             fsm_state
);
  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

  state_t            state, state_next;
  logic [11:0]       bank_a [FRAME_LEN];
  logic [11:0]       bank_b [FRAME_LEN];
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_idx;
  logic              store_en;
  logic [11:0]       store_val;
  logic              frame_end;
  logic              swap;
  logic              overrun_next;
  logic              rd_sel_next;
  logic [11:0]       rd_word;

`ifdef SAMPLE_AVG2_EN
  logic        pair_phase;
  logic [11:0] pair_first;
  logic [12:0] pair_sum;

  assign pair_sum  = {1'b0, pair_first} + {1'b0, bus.sample_data};
  assign store_en  = !reset && bus.sample_valid && pair_phase;
  assign store_val = pair_sum[12:1] ^ 12'h800;

  // Pair phase is independent of bank swaps and overruns.
  always_ff @(posedge clk) begin
    if (reset) pair_phase <= 1'b0;
    else if (bus.sample_valid) pair_phase <= ~pair_phase;
  end

  always_ff @(posedge clk) begin
    if (!reset && bus.sample_valid && !pair_phase) pair_first <= bus.sample_data;
  end
`else
  assign store_en  = !reset && bus.sample_valid;
  assign store_val = bus.sample_data ^ 12'h800;
`endif

  assign frame_end       = store_en && (wr_idx == ADDR_W'(FRAME_LEN - 1));
  assign bus.frame_ready = (state == HELD);
  assign fsm_state       = state;

  // An ack on the frame-completing edge counts as arriving first, so the new
  // frame swaps in rather than being dropped.
  always_comb begin
    state_next   = state;
    swap         = 1'b0;
    overrun_next = 1'b0;
    case (state)
      EMPTY: begin
        if (frame_end) begin
          swap       = 1'b1;
          state_next = HELD;
        end
      end
      HELD: begin
        if (frame_end) begin
          if (bus.frame_ack) swap = 1'b1;
          else overrun_next = 1'b1;
        end else if (bus.frame_ack) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // wr_sel=1 means bank B is the write bank; the read bank is the other one.
  assign rd_sel_next = swap ? wr_sel : ~wr_sel;

  // On a swap edge the last sample is still being written, so forward it.
  always_comb begin
    rd_word = 12'h000;
    if (swap && (bus.rd_addr == wr_idx)) rd_word = store_val;
    else if (rd_sel_next) rd_word = bank_b[bus.rd_addr];
    else rd_word = bank_a[bus.rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      wr_sel      <= 1'b0;
      wr_idx      <= '0;
      bus.overrun <= 1'b0;
      bus.rd_data <= 12'h000;
    end else begin
      state       <= state_next;
      bus.overrun <= overrun_next;
      bus.rd_data <= rd_word;
      if (swap) wr_sel <= ~wr_sel;
      if (store_en) wr_idx <= wr_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (store_en) begin
      if (wr_sel) bank_b[wr_idx] <= store_val;
      else bank_a[wr_idx] <= store_val;
    end
  end
endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer: drivers push expected read data into a
// queue, and a monitor compares it against rd_data one cycle after each read.
module tb_sample_framer;
  localparam int FRAME_LEN = 64;
  localparam int ADDR_W    = 6;

  logic clk = 1'b0;
  logic reset;
  logic fsm_state;

  sample_framer_if #(.ADDR_W(ADDR_W)) bus ();

  sample_framer #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_vec    = 0;
  int          n_fail   = 0;
  int          ovr_seen = 0;
  logic [11:0] exp_q[$];
  logic        rd_req   = 1'b0;
  logic        rd_req_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) rd_req_d <= rd_req;

  always @(negedge clk) begin
    if (bus.overrun) ovr_seen++;
    if (rd_req_d) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL rd_data: got 0x%0h with no expected entry queued", bus.rd_data);
      end else begin
        check("rd_data", {20'h0, bus.rd_data}, {20'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input logic [11:0] data, input logic ack, input logic rd,
                        input logic [ADDR_W-1:0] addr, input logic [11:0] exp);
    bus.sample_valid = 1'b1;
    bus.sample_data  = data;
    bus.frame_ack    = ack;
    if (rd) begin
      bus.rd_addr = addr;
      rd_req      = 1'b1;
      exp_q.push_back(exp);
    end
    tick();
    bus.sample_valid = 1'b0;
    bus.frame_ack    = 1'b0;
    rd_req           = 1'b0;
  endtask

  task automatic sample(input logic [11:0] data);
    strobe(data, 1'b0, 1'b0, '0, 12'h000);
    idle(15);
  endtask

  task automatic read(input logic [ADDR_W-1:0] addr, input logic [11:0] exp);
    bus.rd_addr = addr;
    rd_req      = 1'b1;
    exp_q.push_back(exp);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic ack();
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
  endtask

  // Inputs held active during reset must be ignored.
  task automatic do_reset();
    reset            = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_data  = 12'hFFF;
    bus.frame_ack    = 1'b1;
    bus.rd_addr      = '0;
    idle(2);
    check("reset_frame_ready", {31'h0, bus.frame_ready}, 32'h0);
    check("reset_overrun", {31'h0, bus.overrun}, 32'h0);
    check("reset_rd_data", {20'h0, bus.rd_data}, 32'h0);
    check("reset_fsm_state", {31'h0, fsm_state}, 32'h0);
    reset            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.frame_ack    = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_data  = 12'h000;
    bus.frame_ack    = 1'b0;
    bus.rd_addr      = '0;
    do_reset();

`ifdef SAMPLE_AVG2_EN
    sample(12'd4095);
    sample(12'd4094);
    sample(12'd0);
    sample(12'd1);
    for (int k = 4; k < 2 * FRAME_LEN - 1; k++) sample(12'd0);
    check("avg_ready_before", {31'h0, bus.frame_ready}, 32'h0);
    strobe(12'd0, 1'b0, 1'b0, '0, 12'h000);
    check("avg_ready_after", {31'h0, bus.frame_ready}, 32'h1);
    idle(15);
    read(6'd0, 12'h7FE);
    read(6'd1, 12'h800);
    read(6'd2, 12'h800);
`else
    // Frame 1: k*64, ready rises the cycle after the 64th sample.
    for (int k = 0; k < FRAME_LEN - 1; k++) sample(12'(k * 64));
    check("f1_ready_before", {31'h0, bus.frame_ready}, 32'h0);
    strobe(12'(63 * 64), 1'b0, 1'b0, '0, 12'h000);
    check("f1_ready_after", {31'h0, bus.frame_ready}, 32'h1);
    check("f1_no_overrun", {31'h0, bus.overrun}, 32'h0);
    idle(15);
    read(6'd5, 12'h940);
    read(6'd0, 12'h800);
    read(6'd63, 12'h7C0);

    // Frame 2, never acked: dropped with a single overrun pulse.
    for (int k = 0; k < FRAME_LEN - 1; k++) sample(12'(k * 64 + 7));
    strobe(12'(63 * 64 + 7), 1'b0, 1'b0, '0, 12'h000);
    check("f2_overrun_pulse", {31'h0, bus.overrun}, 32'h1);
    check("f2_ready_held", {31'h0, bus.frame_ready}, 32'h1);
    tick();
    check("f2_overrun_clear", {31'h0, bus.overrun}, 32'h0);
    idle(14);
    read(6'd0, 12'h800);
    read(6'd5, 12'h940);

    // Frame 3: ack coincides with the last sample, read addr 63 on the swap edge.
    for (int k = 0; k < FRAME_LEN - 1; k++) sample(12'(12'h123 + k));
    strobe(12'h162, 1'b1, 1'b1, 6'd63, 12'h962);
    check("f3_no_overrun", {31'h0, bus.overrun}, 32'h0);
    check("f3_ready_held", {31'h0, bus.frame_ready}, 32'h1);
    tick();
    check("f3_no_overrun_late", {31'h0, bus.overrun}, 32'h0);
    read(6'd0, 12'h923);
    read(6'd5, 12'h928);

    // Release, then ack while EMPTY is ignored.
    ack();
    check("ack_ready_low", {31'h0, bus.frame_ready}, 32'h0);
    ack();
    check("ack_empty_ready", {31'h0, bus.frame_ready}, 32'h0);
    check("ack_empty_state", {31'h0, fsm_state}, 32'h0);

    // Partial frame discarded by reset; a full 64 is needed afterwards.
    for (int k = 0; k < 30; k++) sample(12'h555);
    do_reset();
    for (int k = 0; k < FRAME_LEN - 1; k++) sample(12'(k * 32));
    check("f4_ready_before", {31'h0, bus.frame_ready}, 32'h0);
    strobe(12'(63 * 32), 1'b0, 1'b0, '0, 12'h000);
    check("f4_ready_after", {31'h0, bus.frame_ready}, 32'h1);
    idle(15);
    read(6'd1, 12'h820);
    read(6'd63, 12'hFE0);
    check("overrun_count", ovr_seen, 32'd1);
`endif

    // ---------------- report ----------------
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d reads never answered, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
